rename_reg_file: RTL and testbench

Parametrised architectural register file with per-register rename tags for the out-of-order core. It sits between the decoder and the ROB. The decoder reads source values, busy flags and rename tags through `NUM_READ` combinational ports and claims a destination register at issue. The ROB writes committed results back. It adds three things over the single-pair register file: tag-checked commit release, a global flush for mispredict recovery, and a live busy-register count.

---
 rtl/rename_reg_file_if.sv | 36 +++
 rtl/rename_reg_file.sv | 94 +++++++++
 tb/tb_rename_reg_file.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_reg_file_if.sv
// Decoder/ROB-facing bundle of the rename register file: read ports, issue claim, commit, flush, busy count.
interface rename_reg_file_if #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int ROB_W    = 4,
  parameter int NUM_READ = 2
) ();
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                      rdy;
  logic [NUM_READ*IDX_W-1:0] rd_idx;
  logic [NUM_READ*XLEN-1:0]  rd_value;
  logic [NUM_READ-1:0]       rd_busy;
  logic [NUM_READ*ROB_W-1:0] rd_tag;
  logic                      issue_valid;
  logic [IDX_W-1:0]          issue_rd;
  logic [ROB_W-1:0]          issue_tag;
  logic                      commit_valid;
  logic [IDX_W-1:0]          commit_rd;
  logic [ROB_W-1:0]          commit_tag;
  logic [XLEN-1:0]           commit_value;
  logic                      flush;
  logic [IDX_W:0]            busy_count;

  modport master (
    output rdy, rd_idx, issue_valid, issue_rd, issue_tag,
           commit_valid, commit_rd, commit_tag, commit_value, flush,
    input  rd_value, rd_busy, rd_tag, busy_count
  );

  modport slave (
    input  rdy, rd_idx, issue_valid, issue_rd, issue_tag,
           commit_valid, commit_rd, commit_tag, commit_value, flush,
    output rd_value, rd_busy, rd_tag, busy_count
  );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags: 0-cycle reads, 1-cycle issue/commit/flush, no backpressure (rdy stalls all state).
// Define RENAME_REG_FILE_BYPASS_EN to forward a same-cycle commit onto the read ports.
module rename_reg_file #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int ROB_W    = 4,
  parameter int NUM_READ = 2
) (
  input logic               clk,
  input logic               rst,
  rename_reg_file_if.slave  rf
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [XLEN-1:0]  value_q [NUM_REGS];
  logic [XLEN-1:0]  value_d [NUM_REGS];
  logic [ROB_W-1:0] tag_q   [NUM_REGS];
  logic [ROB_W-1:0] tag_d   [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [IDX_W:0]      busy_count_q, busy_count_d;

  logic commit_hit;
  logic commit_clr;

  assign commit_hit = rf.commit_valid && (rf.commit_rd != '0);
  // Only the youngest rename of a register may release it; older commits just deposit their value.
  assign commit_clr = commit_hit && busy_q[rf.commit_rd] && (tag_q[rf.commit_rd] == rf.commit_tag);

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (rf.rdy) begin
      if (commit_hit) begin
        value_d[rf.commit_rd] = rf.commit_value;
      end
      if (commit_clr) begin
        busy_d[rf.commit_rd] = 1'b0;
        tag_d[rf.commit_rd]  = '0;
      end
      if (rf.flush) begin
        busy_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          tag_d[i] = '0;
        end
      end else if (rf.issue_valid && (rf.issue_rd != '0)) begin
        busy_d[rf.issue_rd] = 1'b1;
        tag_d[rf.issue_rd]  = rf.issue_tag;
      end
    end
    busy_count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + (IDX_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q      <= '{default: '0};
      tag_q        <= '{default: '0};
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      value_q      <= value_d;
      tag_q        <= tag_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign rf.busy_count = busy_count_q;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [IDX_W-1:0] idx;
    logic             zero;
    logic [XLEN-1:0]  val;
    logic             busy;

    assign idx  = rf.rd_idx[k*IDX_W +: IDX_W];
    assign zero = rst || (idx == '0);
`ifdef RENAME_REG_FILE_BYPASS_EN
    logic fwd;
    assign fwd  = rf.rdy && commit_hit && (rf.commit_rd == idx);
    assign val  = zero ? '0 : (fwd ? rf.commit_value : value_q[idx]);
    assign busy = !zero && busy_q[idx] && !(fwd && commit_clr);
`else
    assign val  = zero ? '0 : value_q[idx];
    assign busy = !zero && busy_q[idx];
`endif
    assign rf.rd_value[k*XLEN +: XLEN]  = val;
    assign rf.rd_busy[k]                = busy;
    assign rf.rd_tag[k*ROB_W +: ROB_W]  = busy ? tag_q[idx] : '0;
  end
endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboarded bench for rename_reg_file: directed scenarios then random traffic against an array-based reference model.
module tb_rename_reg_file;
  localparam int NR = 32;
  localparam int XL = 32;
  localparam int RW = 4;
  localparam int NP = 2;
  localparam int IW = 5;

  typedef struct packed {
    logic [NP*XL-1:0] v;
    logic [NP-1:0]    b;
    logic [NP*RW-1:0] t;
    logic [IW:0]      cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_vld = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [XL-1:0] m_val  [NR];
  logic          m_busy [NR];
  logic [RW-1:0] m_tag  [NR];

  rename_reg_file_if #(.NUM_REGS(NR), .XLEN(XL), .ROB_W(RW), .NUM_READ(NP)) rf ();

  rename_reg_file #(.NUM_REGS(NR), .XLEN(XL), .ROB_W(RW), .NUM_READ(NP)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  task automatic drive_idle();
    rf.rdy = 1'b1; rf.issue_valid = 1'b0; rf.commit_valid = 1'b0; rf.flush = 1'b0;
    rf.issue_rd = '0; rf.issue_tag = '0; rf.commit_rd = '0; rf.commit_tag = '0; rf.commit_value = '0;
  endtask

  // Drives one cycle of stimulus, records what the read ports must show now and the count after the edge.
  task automatic step(input logic rdy, input logic iv, input logic [IW-1:0] ir, input logic [RW-1:0] it,
                      input logic cv, input logic [IW-1:0] cr, input logic [RW-1:0] ct,
                      input logic [XL-1:0] cval, input logic fl,
                      input logic [IW-1:0] r0, input logic [IW-1:0] r1);
    exp_t e;
    logic [IW-1:0] ri;
    logic [XL-1:0] v;
    logic          b;
    logic [RW-1:0] t;
    @(negedge clk);
    rf.rdy = rdy; rf.issue_valid = iv; rf.issue_rd = ir; rf.issue_tag = it;
    rf.commit_valid = cv; rf.commit_rd = cr; rf.commit_tag = ct; rf.commit_value = cval;
    rf.flush = fl; rf.rd_idx = {r1, r0};
    for (int k = 0; k < NP; k++) begin
      ri = (k == 0) ? r0 : r1;
      if (ri == 0) begin
        v = '0; b = 1'b0; t = '0;
      end else begin
        v = m_val[ri]; b = m_busy[ri]; t = m_busy[ri] ? m_tag[ri] : '0;
`ifdef RENAME_REG_FILE_BYPASS_EN
        if (rdy && cv && cr == ri) begin
          v = cval;
          if (m_busy[ri] && m_tag[ri] == ct) begin b = 1'b0; t = '0; end
        end
`endif
      end
      e.v[k*XL +: XL] = v; e.b[k] = b; e.t[k*RW +: RW] = t;
    end
    if (rdy) begin
      if (cv && cr != 0) begin
        m_val[cr] = cval;
        if (m_busy[cr] && m_tag[cr] == ct) begin m_busy[cr] = 1'b0; m_tag[cr] = '0; end
      end
      if (fl) begin
        for (int i = 0; i < NR; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
      end else if (iv && ir != 0) begin
        m_busy[ir] = 1'b1; m_tag[ir] = it;
      end
    end
    e.cnt = (IW+1)'(model_count());
    exp_q.push_back(e);
    drv_vld = 1'b1;
  endtask

  task automatic check_now(input string tn, input logic [XL-1:0] v, input logic b,
                           input logic [RW-1:0] t, input logic [IW:0] c);
    #2;
    for (int k = 0; k < NP; k++) begin
      check({tn, " value"}, rf.rd_value[k*XL +: XL], v);
      check({tn, " busy"}, 32'(rf.rd_busy[k]), 32'(b));
      check({tn, " tag"}, 32'(rf.rd_tag[k*RW +: RW]), 32'(t));
    end
    check({tn, " busy_count"}, 32'(rf.busy_count), 32'(c));
  endtask

  task automatic expect_reg(input string tn, input logic [IW-1:0] idx, input logic [XL-1:0] v,
                            input logic b, input logic [RW-1:0] t, input logic [IW:0] c);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, idx, idx);
    check_now(tn, v, b, t, c);
  endtask

  task automatic rand_step();
    logic [IW-1:0] cr, ir, r0, r1;
    logic [RW-1:0] ct, it;
    cr = IW'($urandom_range(0, 15));
    ct = ($urandom_range(0, 3) == 0) ? RW'($urandom_range(0, 15)) : m_tag[cr];
    ir = IW'($urandom_range(0, 15));
    it = RW'($urandom_range(0, 15));
    r0 = ($urandom_range(0, 3) == 0) ? cr : IW'($urandom_range(0, 15));
    r1 = IW'($urandom_range(0, 15));
    step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, ir, it,
         $urandom_range(0, 1) == 1, cr, ct, $urandom, $urandom_range(0, 19) == 0, r0, r1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (drv_vld) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow: got empty queue want pending entry");
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < NP; k++) begin
            check("sb rd_value", rf.rd_value[k*XL +: XL], e.v[k*XL +: XL]);
            check("sb rd_busy", 32'(rf.rd_busy[k]), 32'(e.b[k]));
            check("sb rd_tag", 32'(rf.rd_tag[k*RW +: RW]), 32'(e.t[k*RW +: RW]));
          end
          @(posedge clk);
          #1;
          check("sb busy_count", 32'(rf.busy_count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin : main
    model_reset();
    drive_idle();
    rf.rd_idx = {IW'(5), IW'(5)};
    @(negedge clk);
    rf.commit_valid = 1'b1; rf.commit_rd = IW'(5); rf.commit_value = 32'hCAFE_F00D;
    #2;
    check("reset rd_value", rf.rd_value[XL-1:0], 32'h0);
    check("reset rd_busy", 32'(rf.rd_busy), 32'h0);
    check("reset rd_tag", 32'(rf.rd_tag), 32'h0);
    check("reset busy_count", 32'(rf.busy_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    expect_reg("reset_x5", 5, 0, 0, 0, 0);

    step(1, 1, 3, 7, 0, 0, 0, 0, 0, 3, 3);
    expect_reg("issue_x3", 3, 0, 1, 7, 1);
    step(1, 0, 0, 0, 1, 3, 7, 32'hDEADBEEF, 0, 3, 3);
    expect_reg("commit_x3", 3, 32'hDEADBEEF, 0, 0, 0);

    step(1, 1, 4, 2, 0, 0, 0, 0, 0, 4, 4);
    step(1, 1, 4, 5, 0, 0, 0, 0, 0, 4, 4);
    step(1, 0, 0, 0, 1, 4, 2, 32'h11, 0, 4, 4);
    expect_reg("stale_x4", 4, 32'h11, 1, 5, 1);
    step(1, 0, 0, 0, 1, 4, 5, 32'h12, 0, 4, 4);
    expect_reg("clear_x4", 4, 32'h12, 0, 0, 0);

    step(1, 1, 6, 1, 0, 0, 0, 0, 0, 6, 6);
    step(1, 1, 6, 9, 1, 6, 1, 32'h22, 0, 6, 6);
    expect_reg("same_cycle_x6", 6, 32'h22, 1, 9, 1);

    step(1, 1, 7, 3, 0, 0, 0, 0, 0, 7, 7);
    step(1, 1, 11, 4, 0, 0, 0, 0, 0, 11, 11);
    expect_reg("pre_flush_x7", 7, 0, 1, 3, 3);
    step(1, 1, 9, 6, 1, 8, 0, 32'h33, 1, 8, 9);
    expect_reg("flush_x8", 8, 32'h33, 0, 0, 0);
    expect_reg("flush_x9", 9, 0, 0, 0, 0);
    expect_reg("flush_x6", 6, 32'h22, 0, 0, 0);

    step(1, 1, 0, 5, 1, 0, 0, 32'h55, 0, 0, 0);
    expect_reg("x0", 0, 0, 0, 0, 0);

    step(1, 1, 13, 8, 0, 0, 0, 0, 0, 13, 13);
    step(0, 1, 12, 2, 1, 13, 8, 32'h99, 1, 13, 12);
    expect_reg("rdy_low_x13", 13, 0, 1, 8, 1);
    expect_reg("rdy_low_x12", 12, 0, 0, 0, 1);

    step(1, 1, 10, 3, 0, 0, 0, 0, 0, 10, 10);
    step(1, 0, 0, 0, 1, 10, 3, 32'h44, 0, 10, 10);
`ifdef RENAME_REG_FILE_BYPASS_EN
    check_now("bypass_x10", 32'h44, 0, 0, 2);
`else
    check_now("no_bypass_x10", 0, 1, 3, 2);
`endif
    expect_reg("commit_x10", 10, 32'h44, 0, 0, 1);

    for (int n = 0; n < 400; n++) rand_step();

    @(negedge clk);
    drv_vld = 1'b0;
    drive_idle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset busy_count", 32'(rf.busy_count), 32'h0);
    check("midreset rd_busy", 32'(rf.rd_busy), 32'h0);
    check("midreset rd_value", rf.rd_value[XL-1:0], 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 150; n++) rand_step();

    @(negedge clk);
    drv_vld = 1'b0;
    drive_idle();
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("sb drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
